// File: rtl/irq_prio_ctrl.sv
// Priority interrupt controller feeding CP0.
// Synchronises three external interrupt lines, latches their requests, applies
// a software enable mask, tracks nested in-service levels and drives the
// registered 3-bit interruptSignal level (0 = none, 1..3; 3 is highest).
module irq_prio_ctrl #(
    parameter int SYNC_STAGES = 2,    // synchroniser flops per line, 2..4
    parameter bit EDGE_MODE   = 1'b1  // 1 = rising-edge requests, 0 = level
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] irq_raw,
    input  logic       mask_we,
    input  logic [2:0] mask_wdata,
    input  logic       int_ack,
    input  logic       eret_done,
    input  logic       ovf_clr,
    output logic [2:0] interruptSignal,
    output logic [2:0] pending,
    output logic [2:0] in_service,
    output logic [2:0] mask,
    output logic [2:0] overflow
);

    // Highest set bit of a 3-bit vector as a level number (0 when empty).
    function automatic logic [1:0] top_lvl(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  prev_q;
    logic [2:0]                  sync_s;
    logic [2:0]                  req;
    logic [2:0]                  ack_vec;
    logic [2:0]                  retire_vec;
    logic [2:0]                  held_pend;
    logic [2:0]                  pending_nxt;
    logic [2:0]                  isr_nxt;
    logic [2:0]                  mask_nxt;
    logic [2:0]                  overflow_nxt;
    logic [2:0]                  lvl_nxt;
    logic [1:0]                  cand_lvl;
    logic [1:0]                  isr_lvl;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one cycle of edge history on its output.
    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // active-low reset, so every flop clears the instant rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            prev_q <= sync_s;
        end
    end

    // Request decode, ack/retire decode and next-state computation.
    // NOTE: every always_comb output receives a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        req          = EDGE_MODE ? (sync_s & ~prev_q) : sync_s;
        ack_vec      = 3'b000;
        retire_vec   = 3'b000;
        if (int_ack && (interruptSignal != 3'd0))
            ack_vec[interruptSignal[1:0] - 2'd1] = 1'b1;
        if (eret_done && (in_service != 3'b000))
            retire_vec[top_lvl(in_service) - 2'd1] = 1'b1;

        // Retire works on the pre-ack in_service, then the ack bit is added.
        isr_nxt      = (in_service & ~retire_vec) | ack_vec;
        held_pend    = pending & ~ack_vec;
        pending_nxt  = req | held_pend;
        overflow_nxt = (ovf_clr ? 3'b000 : overflow)
                     | (EDGE_MODE ? (req & held_pend) : 3'b000);
        mask_nxt     = mask_we ? mask_wdata : mask;

        // A freshly latched request is offered to the selector one edge after
        // it lands in pending; acks, retires and mask writes count at once so
        // a just-taken level is never shown stale.
        cand_lvl     = top_lvl(held_pend & mask_nxt);
        isr_lvl      = top_lvl(isr_nxt);
        lvl_nxt      = (cand_lvl > isr_lvl) ? {1'b0, cand_lvl} : 3'd0;
    end

    // Controller state registers and the registered level to CP0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending         <= '0;
            in_service      <= '0;
            mask            <= '0;
            overflow        <= '0;
            interruptSignal <= '0;
        end else begin
            pending         <= pending_nxt;
            in_service      <= isr_nxt;
            mask            <= mask_nxt;
            overflow        <= overflow_nxt;
            interruptSignal <= lvl_nxt;
        end
    end

endmodule

// File: doc/irq_prio_ctrl.md
Name: irq_prio_ctrl

Overview:
- Priority interrupt controller directly upstream of the CP0 block.
- Synchronises three asynchronous external interrupt lines and latches their requests.
- Applies a software-written enable mask and tracks nested in-service levels.
- Drives the 3-bit interruptSignal level (0 = none, 1..3) that CP0 compares against its current ring. CP0 acknowledges the grant on interrupt entry and reports completion on ERET.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per irq line (legal 2..4)
EDGE_MODE, 1, 1 = rising-edge triggered requests; 0 = level-sensitive requests

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  one clock; reset is asynchronous and active-low
irq_raw  input  3  asynchronous external interrupt lines; bit i maps to level i+1
mask_we  input  1  write strobe for enable mask
mask_wdata  input  3  new enable mask; bit=1 enables the source
int_ack  input  1  one-cycle pulse from CP0: current interruptSignal taken
eret_done  input  1  one-cycle pulse from CP0 (eret_clearSignal): handler finished
ovf_clr  input  1  clears sticky overflow flags
interruptSignal  output  3  registered granted level to CP0, 0..3
pending  output  3  latched, not-yet-acknowledged requests
in_service  output  3  acknowledged, not-yet-retired levels
mask  output  3  current enable mask
overflow  output  3  sticky: request lost because the source was already pending

Behaviour:
- Reset (rst low, async): synchronisers, edge history, pending, in_service, mask, overflow and interruptSignal are all 0. Every source is disabled at reset.
- Synchroniser: SYNC_STAGES flops per line; s = last stage output, prev = s delayed by one cycle.
- Request condition:
  - EDGE_MODE=1: req[i] = s[i] & ~prev[i].
  - EDGE_MODE=0: req[i] = s[i].
- Pending update, per bit i:
  - set if req[i];
  - else cleared if ack_hit[i];
  - else hold.
  - Set wins over a same-cycle clear.
- Overflow: in EDGE_MODE=1 only, req[i] & pending[i] & ~ack_hit[i] sets overflow[i].
  - ovf_clr clears all overflow bits.
  - A same-cycle new overflow wins over ovf_clr.
  - Never set in level mode.
- Grant ack: ack_hit = int_ack & (interruptSignal != 0). Bit L-1 is hit, where L is the current registered interruptSignal.
  - On ack_hit: pending[L-1] cleared and in_service[L-1] set.
  - int_ack while interruptSignal == 0 is ignored; no state change.
- Retire: eret_done clears the highest set in_service bit; no effect if in_service == 0.
  - eret_done and int_ack in the same cycle: the retire applies to the pre-ack in_service, then the ack bit is set.
- Mask: mask_we loads mask_wdata at the clock edge. Masking never clears pending; a masked request stays pending and is granted once re-enabled.
- Level selection, computed from next-state values and registered into interruptSignal:
  - cand = highest index i with pending[i] & mask[i]; cand_lvl = i+1, or 0 if none.
  - isr_lvl = highest set in_service index + 1, or 0.
  - interruptSignal <= (cand_lvl > isr_lvl) ? cand_lvl : 0.
  - A higher level therefore preempts a lower in-service one; equal or lower levels wait for retirement.
- Latency:
  - EDGE_MODE=1 with mask enabled and in_service empty: interruptSignal reaches the level on the (SYNC_STAGES+2)-th rising edge counting the first edge that samples irq_raw high.
  - After ack_hit, interruptSignal changes on the very next edge. It is never shown stale for a cycle.
- Level mode: pending re-sets every cycle while the line stays high. The handler must deassert the source before issuing ERET.
- Priority: 3 > 2 > 1, fixed.

Test Plan:
- Reset, mask_wdata=3'b111, pulse irq_raw[0] high at edge 0 (SYNC_STAGES=2) -> interruptSignal=1 from edge 3; pending=3'b001.
- With level 1 granted, int_ack -> next cycle pending=0, in_service=3'b001, interruptSignal=0; eret_done -> in_service=0.
- Level 1 in service, raise irq_raw[2] -> interruptSignal=3 (preempt).
  - Ack -> in_service=3'b101.
  - Raise irq_raw[1] -> interruptSignal stays 0.
  - eret_done -> in_service=3'b001, interruptSignal=2 next edge.
- mask=3'b000, pulse irq_raw[1] -> pending=3'b010, interruptSignal=0; write mask=3'b010 -> interruptSignal=2 one edge later.
- Two rising edges on irq_raw[0] without ack -> overflow=3'b001.
  - ovf_clr asserted together with a third edge -> overflow stays 3'b001.
  - ovf_clr alone -> overflow=0.
- Drop rst mid-operation with pending=3'b111, in_service=3'b010 -> all outputs 0 immediately, without waiting for a clock; interruptSignal stays 0 after release until new requests arrive.
